// File: rtl/rename_dispatch_ctrl.sv
// Credit-based dispatch gate in front of Rename: tracks ROB/IQ/LSQ slots and free pregs,
// and blocks dispatch for a fixed recovery window after a flush.

module rdc_credit_ctr #(
    parameter int SIZE = 16,
    parameter int W    = $clog2(SIZE + 1)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         reload,
    input  logic         alloc,
    input  logic         release_i,
    output logic [W-1:0] count,
    output logic         err
);
    localparam logic [W-1:0] FULL = W'(SIZE);

    logic [W-1:0] cnt_nxt;

    // alloc and release together cancel; out-of-range moves clamp and flag
    always_comb begin
        cnt_nxt = count;
        err     = 1'b0;
        if (alloc && !release_i) begin
            if (count == '0) err = 1'b1;
            else             cnt_nxt = count - 1'b1;
        end else if (release_i && !alloc) begin
            if (count == FULL) err = 1'b1;
            else               cnt_nxt = count + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET)      count <= FULL;
        else if (reload) count <= FULL;
        else             count <= cnt_nxt;
    end
endmodule

module rename_dispatch_ctrl #(
    parameter int ROB_SIZE       = 32,
    parameter int IQ_SIZE        = 16,
    parameter int LSQ_SIZE       = 16,
    parameter int FREE_REGS      = 32,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             FLUSH,
    input  logic                             STALL,
    input  logic                             rn_valid,
    input  logic                             rn_dst,
    input  logic                             rn_ld,
    input  logic                             rn_st,
    input  logic                             rob_release,
    input  logic                             iq_release,
    input  logic                             lsq_release,
    input  logic                             rrat_free,
    output logic                             dispatch,
    output logic                             halt_rename_queue,
    output logic [$clog2(ROB_SIZE+1)-1:0]    rob_credits,
    output logic [$clog2(IQ_SIZE+1)-1:0]     iq_credits,
    output logic [$clog2(LSQ_SIZE+1)-1:0]    lsq_credits,
    output logic [$clog2(FREE_REGS+1)-1:0]   free_count,
    output logic                             recovering,
    output logic                             credit_err
);
    localparam int RCW = ($clog2(RECOVER_CYCLES) < 3) ? 3 : $clog2(RECOVER_CYCLES);
    localparam logic [RCW-1:0] RC_LOAD = RCW'(RECOVER_CYCLES - 1);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t         state, state_nxt;
    logic [RCW-1:0] rc_cnt, rc_nxt;
    logic           run;
    logic           needs_lsq, needs_preg;
    logic [3:0]     ctr_err;

    assign run        = (state == RUN);
    assign needs_lsq  = rn_ld | rn_st;
    assign needs_preg = rn_dst | rn_ld;

    always_comb begin
        dispatch = rn_valid && run && !STALL && !FLUSH
                && (rob_credits != '0) && (iq_credits != '0)
                && (!needs_lsq  || (lsq_credits != '0))
                && (!needs_preg || (free_count  != '0));
        halt_rename_queue = rn_valid && !dispatch;
        recovering        = !run;
    end

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc_cnt;
        if (FLUSH) begin
            state_nxt = RECOVER;
            rc_nxt    = RC_LOAD;
        end else if (state == RECOVER) begin
            if (rc_cnt == '0) state_nxt = RUN;
            else              rc_nxt    = rc_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= RUN;
            rc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rc_cnt <= rc_nxt;
        end
    end

    // releases only count while running; a flush reload overrides them
    rdc_credit_ctr #(.SIZE(ROB_SIZE)) u_rob (
        .CLK(CLK), .RESET(RESET), .reload(FLUSH),
        .alloc(dispatch), .release_i(rob_release & run),
        .count(rob_credits), .err(ctr_err[0]));

    rdc_credit_ctr #(.SIZE(IQ_SIZE)) u_iq (
        .CLK(CLK), .RESET(RESET), .reload(FLUSH),
        .alloc(dispatch), .release_i(iq_release & run),
        .count(iq_credits), .err(ctr_err[1]));

    rdc_credit_ctr #(.SIZE(LSQ_SIZE)) u_lsq (
        .CLK(CLK), .RESET(RESET), .reload(FLUSH),
        .alloc(dispatch & needs_lsq), .release_i(lsq_release & run),
        .count(lsq_credits), .err(ctr_err[2]));

    rdc_credit_ctr #(.SIZE(FREE_REGS)) u_free (
        .CLK(CLK), .RESET(RESET), .reload(FLUSH),
        .alloc(dispatch & needs_preg), .release_i(rrat_free & run),
        .count(free_count), .err(ctr_err[3]));

    always_ff @(posedge CLK) begin
        if (!RESET)                 credit_err <= 1'b0;
        else if (run && !FLUSH && (|ctr_err)) credit_err <= 1'b1;
    end
endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
// Directed-vector bench for rename_dispatch_ctrl with hand-computed expectations.

module tb_rename_dispatch_ctrl;
    logic CLK = 1'b0;
    logic RESET, FLUSH, STALL;
    logic rn_valid, rn_dst, rn_ld, rn_st;
    logic rob_release, iq_release, lsq_release, rrat_free;
    logic dispatch, halt_rename_queue, recovering, credit_err;
    logic [5:0] rob_credits;
    logic [4:0] iq_credits;
    logic [4:0] lsq_credits;
    logic [5:0] free_count;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    always #5 CLK = ~CLK;

    rename_dispatch_ctrl dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
        .rn_valid(rn_valid), .rn_dst(rn_dst), .rn_ld(rn_ld), .rn_st(rn_st),
        .rob_release(rob_release), .iq_release(iq_release),
        .lsq_release(lsq_release), .rrat_free(rrat_free),
        .dispatch(dispatch), .halt_rename_queue(halt_rename_queue),
        .rob_credits(rob_credits), .iq_credits(iq_credits),
        .lsq_credits(lsq_credits), .free_count(free_count),
        .recovering(recovering), .credit_err(credit_err));

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        FLUSH = 0; STALL = 0; rn_valid = 0; rn_dst = 0; rn_ld = 0; rn_st = 0;
        rob_release = 0; iq_release = 0; lsq_release = 0; rrat_free = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 0;
        tick(); tick();
        RESET = 1;
        #1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_rob",  rob_credits, 32);
        chk("rst_iq",   iq_credits, 16);
        chk("rst_lsq",  lsq_credits, 16);
        chk("rst_free", free_count, 32);
        chk("rst_rec",  recovering, 0);
        chk("rst_err",  credit_err, 0);
        chk("rst_disp", dispatch, 0);
        chk("rst_halt", halt_rename_queue, 0);

        // STALL blocks dispatch and halts Rename
        rn_valid = 1; rn_dst = 1; STALL = 1; #1;
        chk("stall_disp", dispatch, 0);
        chk("stall_halt", halt_rename_queue, 1);
        STALL = 0; #1;

        // IQ exhaustion: 32 cycles of requests, only 16 grants
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (dispatch) cnt++;
            tick();
        end
        chk("iq_grants", cnt, 16);
        chk("iq_empty", iq_credits, 0);
        chk("iq_disp0", dispatch, 0);
        chk("iq_halt",  halt_rename_queue, 1);
        iq_release = 1; #1;
        chk("rel_same_cycle", dispatch, 0);
        tick();
        iq_release = 0; #1;
        chk("rel_next_disp", dispatch, 1);
        tick();
        chk("rel_one_only", dispatch, 0);
        chk("rob_after17", rob_credits, 15);
        chk("free_after17", free_count, 15);

        // free-list exhaustion with ROB/IQ held steady by releases
        do_reset();
        rn_valid = 1; rn_dst = 1; rob_release = 1; iq_release = 1; #1;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (dispatch) cnt++;
            tick();
        end
        chk("free_grants", cnt, 32);
        chk("free_zero", free_count, 0);
        chk("free_rob_hold", rob_credits, 32);
        chk("free_33_halt", dispatch, 0);
        rn_dst = 0; #1;
        chk("free_nodst_disp", dispatch, 1);
        tick();
        idle_inputs(); #1;
        chk("free_err_clean", credit_err, 0);

        // LSQ exhaustion with loads, then a store
        do_reset();
        rn_valid = 1; rn_ld = 1; iq_release = 1; #1;
        for (int i = 0; i < 16; i++) tick();
        rn_ld = 0; rn_st = 1; iq_release = 0; #1;
        chk("lsq_zero", lsq_credits, 0);
        chk("lsq_st_halt", dispatch, 0);
        chk("lsq_free", free_count, 16);
        chk("lsq_rob", rob_credits, 16);
        rn_st = 0; rob_release = 1; #1;
        chk("rob_same_disp", dispatch, 1);
        tick();
        idle_inputs(); #1;
        chk("rob_same_hold", rob_credits, 16);
        chk("rob_same_iq", iq_credits, 15);
        chk("lsq_err_clean", credit_err, 0);

        // FLUSH at rob_credits=20, recovery window timing
        do_reset();
        rn_valid = 1; #1;
        for (int i = 0; i < 12; i++) tick();
        chk("pre_flush_rob", rob_credits, 20);
        FLUSH = 1; #1;
        chk("flush_disp", dispatch, 0);
        tick();
        FLUSH = 0; #1;
        chk("flush_rob", rob_credits, 32);
        chk("flush_iq", iq_credits, 16);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("rec%0d_flag", k), recovering, 1);
            chk($sformatf("rec%0d_disp", k), dispatch, 0);
            tick();
        end
        chk("rec_done", recovering, 0);
        chk("rec_first_disp", dispatch, 1);
        idle_inputs(); #1;
        tick();

        // second FLUSH in the 2nd recovery cycle restarts the window
        FLUSH = 1; tick();
        FLUSH = 0; tick();
        chk("reflush_in_rec", recovering, 1);
        FLUSH = 1; tick();
        FLUSH = 0; rn_valid = 1; rob_release = 1; #1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("re%0d_flag", k), recovering, 1);
            tick();
        end
        rob_release = 0; #1;
        chk("re_done", recovering, 0);
        chk("re_disp", dispatch, 1);
        chk("re_rel_ignored_rob", rob_credits, 32);
        chk("re_rel_ignored_err", credit_err, 0);
        idle_inputs(); #1;

        // reset in the middle of recovery
        FLUSH = 1; tick();
        FLUSH = 0; RESET = 0; tick();
        RESET = 1; #1;
        chk("midrec_rst_rec", recovering, 0);
        chk("midrec_rst_rob", rob_credits, 32);

        // release at full: saturate and sticky error
        rob_release = 1; tick();
        rob_release = 0; #1;
        chk("sat_rob", rob_credits, 32);
        chk("sat_err", credit_err, 1);
        FLUSH = 1; tick();
        FLUSH = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_err_sticky", credit_err, 1);
        RESET = 0; tick();
        RESET = 1; #1;
        chk("sat_err_cleared", credit_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
